// File: rtl/mantissa_big_alu.sv
// Mantissa ALU for the single-precision FP unit: combinational add/sub/logic plus sequential shift-add multiply.
// Define BIGALU_EARLY_TERM_EN to let the multiply finish as soon as the remaining multiplier bits are zero.
module mantissa_big_alu #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] valor1,
    input  logic [W-1:0] valor2,
    input  logic [3:0]   ALUOp,
    input  logic         muxA,
    input  logic         muxB,
    input  logic         muxC,
    input  logic         sumOrMultiplication,
    input  logic         loadRegA,
    input  logic         loadRegB,
    output logic [W-1:0] result,
    output logic         carryOut,
    output logic         endMultiplication
);
    // state | meaning
    // IDLE  | waiting for sumOrMultiplication to start a multiply
    // MUL   | one shift-add iteration per edge, counter counts down from W
    // DONE  | product stable, endMultiplication high until request drops
    typedef enum logic [1:0] {IDLE, MUL, DONE} stateType;

    localparam int CW = $clog2(W + 1);

    stateType state, nextState;
    logic [W-1:0]   regA, regB;
    logic [2*W-1:0] mcand, product;
    logic [W-1:0]   mplier;
    logic [CW-1:0]  counter;
    logic           lastIter;

    logic [W-1:0] opA, opB, aluR;
    logic [W:0]   sumFull, diffFull;
    logic         aluCarry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regA <= '0;
            regB <= '0;
        end else begin
            if (loadRegA) regA <= valor1;
            if (loadRegB) regB <= valor2;
        end
    end

`ifdef BIGALU_EARLY_TERM_EN
    // Next mplier is mplier >> 1; once that is zero no further adds can happen.
    assign lastIter = (counter == CW'(1)) || (mplier[W-1:1] == '0);
`else
    assign lastIter = (counter == CW'(1));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (sumOrMultiplication) nextState = MUL;
            MUL: begin
                if (!sumOrMultiplication) nextState = IDLE;
                else if (lastIter)        nextState = DONE;
            end
            DONE: if (!sumOrMultiplication) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        endMultiplication = (state == DONE);
    end

    // Operands are snapshotted at start so reg loads during MUL cannot disturb the run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand   <= '0;
            mplier  <= '0;
            product <= '0;
            counter <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sumOrMultiplication) begin
                        mcand   <= {{W{1'b0}}, regA};
                        mplier  <= regB;
                        product <= '0;
                        counter <= CW'(W);
                    end
                end
                MUL: begin
                    if (!sumOrMultiplication) begin
                        product <= '0;
                    end else begin
                        if (mplier[0]) product <= product + mcand;
                        mcand   <= mcand << 1;
                        mplier  <= mplier >> 1;
                        counter <= counter - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign opA      = muxA ? regA : valor1;
    assign opB      = muxB ? regB : valor2;
    assign sumFull  = {1'b0, opA} + {1'b0, opB};
    assign diffFull = {1'b0, opA} - {1'b0, opB};

    always_comb begin
        aluR     = '0;
        aluCarry = 1'b0;
        case (ALUOp)
            4'b0000: aluR = opA & opB;
            4'b0001: aluR = opA | opB;
            4'b0010: {aluCarry, aluR} = sumFull;
            4'b0110: {aluCarry, aluR} = diffFull;
            4'b0111: aluR = {{(W-1){1'b0}}, (opA < opB)};
            default: begin
                aluR     = '0;
                aluCarry = 1'b0;
            end
        endcase
    end

    assign result   = muxC ? product[2*W-1:W] : aluR;
    assign carryOut = aluCarry;
endmodule

// File: tb/tb_mantissa_big_alu.sv
// Directed self-checking bench for mantissa_big_alu; edge-count expectations follow BIGALU_EARLY_TERM_EN.
module tb_mantissa_big_alu;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] valor1, valor2;
    logic [3:0]  ALUOp;
    logic        muxA, muxB, muxC;
    logic        sumOrMultiplication, loadRegA, loadRegB;
    logic [23:0] result;
    logic        carryOut, endMultiplication;

    int checks = 0;
    int errors = 0;
    int edges;
    bit sawEnd;

    mantissa_big_alu #(.W(24)) dut (
        .clk(clk), .rst_n(rst_n), .valor1(valor1), .valor2(valor2), .ALUOp(ALUOp),
        .muxA(muxA), .muxB(muxB), .muxC(muxC), .sumOrMultiplication(sumOrMultiplication),
        .loadRegA(loadRegA), .loadRegB(loadRegB), .result(result), .carryOut(carryOut),
        .endMultiplication(endMultiplication)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic aluCheck(input string tag, input logic [3:0] op, input logic [23:0] a,
                            input logic [23:0] b, input logic [23:0] expR, input logic expC);
        ALUOp = op; valor1 = a; valor2 = b;
        #1;
        check({tag, "_r"}, 32'(result), 32'(expR));
        check({tag, "_c"}, 32'(carryOut), 32'(expC));
    endtask

    task automatic loadRegs(input logic [23:0] a, input logic [23:0] b);
        valor1 = a; valor2 = b; loadRegA = 1'b1; loadRegB = 1'b1;
        tick();
        loadRegA = 1'b0; loadRegB = 1'b0;
    endtask

    // Raise the request and count edges until endMultiplication (start edge is edge 1).
    task automatic waitDone(output int n);
        n = 0;
        while (!endMultiplication && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic runMul(input string tag, input logic [23:0] a, input logic [23:0] b,
                          input int expEdges, input logic [23:0] expRes);
        int n;
        loadRegs(a, b);
        muxC = 1'b1;
        sumOrMultiplication = 1'b1;
        waitDone(n);
        check({tag, "_edges"}, 32'(n), 32'(expEdges));
        check({tag, "_res"}, 32'(result), 32'(expRes));
        sumOrMultiplication = 1'b0;
        tick();
        check({tag, "_endlow"}, 32'(endMultiplication), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        valor1 = '0; valor2 = '0; ALUOp = 4'b0010;
        muxA = 1'b0; muxB = 1'b0; muxC = 1'b0;
        sumOrMultiplication = 1'b0; loadRegA = 1'b0; loadRegB = 1'b0;
        #12;
        check("rst_result", 32'(result), 32'd0);
        check("rst_carry", 32'(carryOut), 32'd0);
        check("rst_end", 32'(endMultiplication), 32'd0);
        muxC = 1'b1; #1;
        check("rst_product", 32'(result), 32'd0);
        muxC = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        tick();

        aluCheck("add1", 4'b0010, 24'h800000, 24'h400000, 24'hC00000, 1'b0);
        aluCheck("add2", 4'b0010, 24'h800000, 24'h800000, 24'h000000, 1'b1);
        aluCheck("sub1", 4'b0110, 24'hC00000, 24'h400000, 24'h800000, 1'b0);
        aluCheck("sub2", 4'b0110, 24'h400000, 24'hC00000, 24'h800000, 1'b1);
        aluCheck("sub0", 4'b0110, 24'h123456, 24'h123456, 24'h000000, 1'b0);
        aluCheck("bad",  4'b1111, 24'hC00000, 24'hC00000, 24'h000000, 1'b0);
        aluCheck("and",  4'b0000, 24'hC00000, 24'h400000, 24'h400000, 1'b0);
        aluCheck("or",   4'b0001, 24'h800000, 24'h400000, 24'hC00000, 1'b0);
        aluCheck("slt1", 4'b0111, 24'h400000, 24'hC00000, 24'h000001, 1'b0);
        aluCheck("slt0", 4'b0111, 24'hC00000, 24'h400000, 24'h000000, 1'b0);

        // Register-sourced operands
        loadRegs(24'h00F00F, 24'h0F0F00);
        muxA = 1'b1; muxB = 1'b1;
        aluCheck("regadd", 4'b0010, 24'h0, 24'h0, 24'h0FFF0F, 1'b0);
        muxA = 1'b0;
        aluCheck("mixand", 4'b0000, 24'hFFFFFF, 24'h0, 24'h0F0F00, 1'b0);
        muxB = 1'b0;

        runMul("mul88", 24'h800000, 24'h800000, 25, 24'h400000);

        // Second multiply with hold/handshake and a regA reload mid-run
        loadRegs(24'hC00000, 24'hC00000);
        muxC = 1'b1;
        sumOrMultiplication = 1'b1;
        repeat (5) tick();
        valor1 = 24'h123456; loadRegA = 1'b1;
        tick();
        loadRegA = 1'b0;
        edges = 6;
        while (!endMultiplication && edges < 40) begin
            tick();
            edges++;
        end
        check("mulCC_edges", 32'(edges), 32'd25);
        check("mulCC_res", 32'(result), 32'h900000);
        repeat (3) tick();
        check("hold_end", 32'(endMultiplication), 32'd1);
        check("hold_res", 32'(result), 32'h900000);
        sumOrMultiplication = 1'b0;
        tick();
        check("release_end", 32'(endMultiplication), 32'd0);

        `ifdef BIGALU_EARLY_TERM_EN
        runMul("mulB1", 24'h800000, 24'h000001, 2, 24'h000000);
        runMul("mulB0", 24'h800000, 24'h000000, 2, 24'h000000);
        runMul("mulB3", 24'hFFFFFF, 24'h000003, 3, 24'h000002);
        `else
        runMul("mulB1", 24'h800000, 24'h000001, 25, 24'h000000);
        runMul("mulB0", 24'h800000, 24'h000000, 25, 24'h000000);
        runMul("mulB3", 24'hFFFFFF, 24'h000003, 25, 24'h000002);
        `endif

        // Abort: request dropped so that edge 10 sees it low
        loadRegs(24'h800000, 24'h800000);
        sumOrMultiplication = 1'b1;
        repeat (9) tick();
        check("abort_pre", 32'(endMultiplication), 32'd0);
        sumOrMultiplication = 1'b0;
        sawEnd = 1'b0;
        repeat (30) begin
            tick();
            if (endMultiplication) sawEnd = 1'b1;
        end
        check("abort_noend", 32'(sawEnd), 32'd0);
        check("abort_prod", 32'(result), 32'd0);

        // Asynchronous reset mid-multiply
        sumOrMultiplication = 1'b1;
        repeat (5) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_prod", 32'(result), 32'd0);
        check("arst_end", 32'(endMultiplication), 32'd0);
        sumOrMultiplication = 1'b0;
        muxC = 1'b0; muxA = 1'b1; muxB = 1'b1;
        aluCheck("arst_regs", 4'b0001, 24'hFFFFFF, 24'hFFFFFF, 24'h000000, 1'b0);
        muxA = 1'b0; muxB = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        tick();

        runMul("post_rst", 24'hC00000, 24'h800000, 25, 24'h600000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
